// File: rtl/multicycle_control_unit_if.sv
// Datapath/control bundle between the multicycle control FSM and the RISC-V datapath.
// The master modport is the control unit. The slave modport is the datapath and memory side.
interface multicycle_control_unit_if #(
  parameter int unsigned ALUOP_W = 2
);
  logic               run;
  logic               power;
  logic [6:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               alusrc;
  logic               mem2reg;
  logic               regwrite;
  logic               memread;
  logic               memwrite;
  logic               branch;
  logic               writepc;
  logic               startpc;
  logic [ALUOP_W-1:0] aluop;
  logic               pcsel;
  logic               illegal;
  logic               mem_timeout;
  logic               busy;

  modport master (
    input  run, power, opcode, zero, mem_ready,
    output alusrc, mem2reg, regwrite, memread, memwrite, branch, writepc, startpc,
           aluop, pcsel, illegal, mem_timeout, busy
  );

  modport slave (
    output run, power, opcode, zero, mem_ready,
    input  alusrc, mem2reg, regwrite, memread, memwrite, branch, writepc, startpc,
           aluop, pcsel, illegal, mem_timeout, busy
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/memory/writeback with a memory timeout.
// Define CU_BRANCH_EN to add the conditional-branch (opcode 1100011) path.
module multicycle_control_unit #(
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned IDLE_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_unit_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST =
    (IDLE_CYCLES == 0) ? '0 : CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [3:0] {
    START, FETCH, DECODE, EXEC_R, EXEC_I, WB_R, ADDR,
    MEM_RD, MEM_WR, WB_LD, IDLE, BRANCH, ERROR
  } state_t;

  typedef struct packed {
    logic       alusrc;
    logic       mem2reg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       writepc;
    logic       busy;
    logic [1:0] aluop;
  } ctrl_t;

  state_t           state, state_next, retire;
  logic [CNT_W-1:0] cnt, cnt_next;
  ctrl_t            ctrl_q, ctrl_next;
  logic             illegal_q, timeout_q;
  logic             set_illegal, set_timeout;
  logic             force_start;

  assign force_start = bus.power & ~bus.run;
  assign retire      = (IDLE_CYCLES == 0) ? FETCH : IDLE;

  // State, wait/idle counter, sticky flags and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= START;
      cnt       <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      ctrl_q <= ctrl_next;
      if (force_start) begin
        illegal_q <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        illegal_q <= illegal_q | set_illegal;
        timeout_q <= timeout_q | set_timeout;
      end
    end
  end

  // Next state, counter, and strobes decoded from the state being entered.
  always_comb begin
    state_next  = state;
    cnt_next    = '0;
    ctrl_next   = '0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    case (state)
      START:  state_next = FETCH;
      FETCH:  state_next = bus.run ? DECODE : FETCH;
      DECODE: begin
        if (bus.opcode == OP_R)                              state_next = EXEC_R;
        else if (bus.opcode == OP_I)                         state_next = EXEC_I;
        else if (bus.opcode == OP_LD || bus.opcode == OP_ST) state_next = ADDR;
`ifdef CU_BRANCH_EN
        else if (bus.opcode == OP_BR)                        state_next = BRANCH;
`endif
        else begin
          state_next  = ERROR;
          set_illegal = 1'b1;
        end
      end
      EXEC_R, EXEC_I: state_next = WB_R;
      WB_R, WB_LD, BRANCH: state_next = retire;
      ADDR:   state_next = (bus.opcode == OP_LD) ? MEM_RD : MEM_WR;
      MEM_RD, MEM_WR: begin
        if (bus.mem_ready) begin
          state_next = (state == MEM_RD) ? WB_LD : retire;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next  = ERROR;
          set_timeout = 1'b1;
        end
      end
      IDLE:   if (cnt == IDLE_LAST) state_next = FETCH;
      ERROR:  state_next = ERROR;
      default: state_next = START;
    endcase

    if (force_start) begin
      state_next  = START;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
    end

    // The counter only runs while staying in a waiting state; any entry clears it.
    if (state_next == state && (state == MEM_RD || state == MEM_WR || state == IDLE)) begin
      cnt_next = cnt + CNT_W'(1);
    end

    case (state_next)
      FETCH:  ctrl_next.writepc = 1'b1;
      DECODE: ctrl_next.busy = 1'b1;
      EXEC_R: begin
        ctrl_next.busy  = 1'b1;
        ctrl_next.aluop = 2'b10;
      end
      EXEC_I: begin
        ctrl_next.busy   = 1'b1;
        ctrl_next.aluop  = 2'b11;
        ctrl_next.alusrc = 1'b1;
      end
      WB_R: begin
        ctrl_next.busy     = 1'b1;
        ctrl_next.regwrite = 1'b1;
      end
      ADDR: begin
        ctrl_next.busy   = 1'b1;
        ctrl_next.aluop  = 2'b00;
        ctrl_next.alusrc = 1'b1;
      end
      MEM_RD: begin
        ctrl_next.busy    = 1'b1;
        ctrl_next.memread = 1'b1;
        ctrl_next.alusrc  = 1'b1;
      end
      MEM_WR: begin
        ctrl_next.busy     = 1'b1;
        ctrl_next.memwrite = 1'b1;
        ctrl_next.alusrc   = 1'b1;
      end
      WB_LD: begin
        ctrl_next.busy     = 1'b1;
        ctrl_next.regwrite = 1'b1;
        ctrl_next.mem2reg  = 1'b1;
      end
      IDLE:   ctrl_next.busy = 1'b1;
`ifdef CU_BRANCH_EN
      BRANCH: begin
        ctrl_next.busy   = 1'b1;
        ctrl_next.branch = 1'b1;
        ctrl_next.aluop  = 2'b01;
      end
`endif
      default: ctrl_next = '0;
    endcase
  end

  assign bus.alusrc      = ctrl_q.alusrc;
  assign bus.mem2reg     = ctrl_q.mem2reg;
  assign bus.regwrite    = ctrl_q.regwrite;
  assign bus.memread     = ctrl_q.memread;
  assign bus.memwrite    = ctrl_q.memwrite;
  assign bus.branch      = ctrl_q.branch;
  assign bus.writepc     = ctrl_q.writepc;
  assign bus.busy        = ctrl_q.busy;
  assign bus.aluop       = ALUOP_W'(ctrl_q.aluop);
  assign bus.illegal     = illegal_q;
  assign bus.mem_timeout = timeout_q;
  // startpc follows power directly so it tracks power even while reset is held.
  assign bus.startpc     = bus.power & (state == START || state == FETCH);
`ifdef CU_BRANCH_EN
  assign bus.pcsel       = ctrl_q.branch & bus.zero;
`else
  assign bus.pcsel       = 1'b0;
`endif

endmodule
